// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for LW/SW and multi-register LM/SM transfers.
// Define MEM_LSU_MULTI_EN to execute LM/SM; otherwise they raise illegal_o.

module mem_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    input  logic [15:0] in_instr_i,
    input  logic [15:0] in_addr_i,
    input  logic [15:0] in_val_i,
    input  logic [2:0]  in_rd_i,
    input  logic        in_wb_en_i,
    output logic        stall_o,
    output logic        load_pending_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [15:0] dmem_addr_o,
    output logic [15:0] dmem_wdata_o,
    input  logic [15:0] dmem_rdata_i,
    input  logic        dmem_ready_i,
    output logic [2:0]  rf_rd_idx_o,
    input  logic [15:0] rf_rd_val_i,
    output logic        wb_valid_o,
    output logic [2:0]  wb_rd_o,
    output logic [15:0] wb_val_o,
    output logic        illegal_o
);

`ifdef MEM_LSU_MULTI_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MULTI} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCESS} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] wb_val_q, wb_val_d;
    logic [2:0]  rd_q, rd_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  mask_left;
    logic [2:0]  cur_idx;
    logic        we_q, we_d;
    logic        load_q, load_d;
    logic        wb_v_q, wb_v_d;
    logic        wb_ld_q, wb_ld_d;
    logic        ill_q, ill_d;
    logic        is_lw, is_sw, is_lm, is_sm;
    logic        accept, multi_ok;
    logic        unused_bits;

    assign is_lw  = in_instr_i[15:12] == 4'b0100;
    assign is_sw  = in_instr_i[15:12] == 4'b0101;
    assign is_lm  = in_instr_i[15:12] == 4'b0110;
    assign is_sm  = in_instr_i[15:12] == 4'b0111;
    assign accept = in_valid_i && (state_q == S_IDLE);

`ifdef MEM_LSU_MULTI_EN
    assign multi_ok = |in_instr_i[7:0];
`else
    assign multi_ok = 1'b0;
`endif

    // Highest remaining mask bit maps to the lowest register number.
    always_comb begin
        cur_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (mask_q[i]) cur_idx = 3'(7 - i);
        end
    end

    assign mask_left = mask_q & ~(8'h80 >> cur_idx);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        mask_d   = mask_q;
        we_d     = we_q;
        load_d   = load_q;
        wb_v_d   = 1'b0;
        wb_rd_d  = wb_rd_q;
        wb_val_d = wb_val_q;
        wb_ld_d  = 1'b0;
        ill_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    unique case (1'b1)
                        is_lw || is_sw: begin
                            state_d = S_ACCESS;
                            addr_d  = in_addr_i;
                            wdata_d = in_val_i;
                            rd_d    = in_rd_i;
                            we_d    = is_sw;
                            load_d  = is_lw;
                        end
                        is_lm || is_sm: begin
`ifdef MEM_LSU_MULTI_EN
                            if (multi_ok) begin
                                state_d = S_MULTI;
                                addr_d  = in_addr_i;
                                mask_d  = in_instr_i[7:0];
                                we_d    = is_sm;
                                load_d  = is_lm;
                            end
`else
                            ill_d = 1'b1;
`endif
                        end
                        default: begin
                            if (in_wb_en_i) begin
                                wb_v_d   = 1'b1;
                                wb_rd_d  = in_rd_i;
                                wb_val_d = in_val_i;
                            end
                        end
                    endcase
                end
            end
            S_ACCESS: begin
                if (dmem_ready_i) begin
                    state_d = S_IDLE;
                    if (load_q) begin
                        wb_v_d   = 1'b1;
                        wb_rd_d  = rd_q;
                        wb_val_d = dmem_rdata_i;
                        wb_ld_d  = 1'b1;
                    end
                end
            end
`ifdef MEM_LSU_MULTI_EN
            S_MULTI: begin
                if (dmem_ready_i) begin
                    addr_d = addr_q + 16'd1;
                    mask_d = mask_left;
                    if (mask_left == 8'h00) state_d = S_IDLE;
                    if (load_q) begin
                        wb_v_d   = 1'b1;
                        wb_rd_d  = cur_idx;
                        wb_val_d = dmem_rdata_i;
                        wb_ld_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rd_q     <= 3'd0;
            mask_q   <= 8'h00;
            we_q     <= 1'b0;
            load_q   <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= 3'd0;
            wb_val_q <= 16'h0000;
            wb_ld_q  <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            mask_q   <= mask_d;
            we_q     <= we_d;
            load_q   <= load_d;
            wb_v_q   <= wb_v_d;
            wb_rd_q  <= wb_rd_d;
            wb_val_q <= wb_val_d;
            wb_ld_q  <= wb_ld_d;
            ill_q    <= ill_d;
        end
    end

    assign stall_o     = state_q != S_IDLE;
    assign dmem_req_o  = state_q != S_IDLE;
    assign dmem_we_o   = we_q && (state_q != S_IDLE);
    assign dmem_addr_o = addr_q;
    assign rf_rd_idx_o = cur_idx;
    assign wb_valid_o  = wb_v_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_val_o    = wb_val_q;
    assign illegal_o   = ill_q;

`ifdef MEM_LSU_MULTI_EN
    assign dmem_wdata_o = (state_q == S_MULTI) ? rf_rd_val_i : wdata_q;
`else
    assign dmem_wdata_o = wdata_q;
`endif

    // Pending covers the accept cycle, the access itself and the final wb cycle.
    assign load_pending_o = (accept && (is_lw || (is_lm && multi_ok)))
                         || ((state_q != S_IDLE) && load_q)
                         || wb_ld_q;

    assign unused_bits = ^{in_instr_i[11:0], rf_rd_val_i, mask_left};

endmodule
